// File: rtl/wb_pkg.sv
// Shared write-back types: a register-file write request as produced by
// the pipeline write-back stage and by the multiply/divide unit.
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // r0 is hard-wired zero, so a write to it carries no information
    function automatic logic addr_live(input logic [REG_AW-1:0] a);
        return a != '0;
    endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the pipeline/MDU side (master) and the write-port arbiter (slave).
// Carries write-back requests, the MDU valid/ready handshake, the hazard probe and the register-file write.
interface wb_port_arbiter_if
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
);
    logic [REG_AW-1:0]        wb_addr;
    logic [XLEN-1:0]          wb_data;
    logic                     wb_write;
    logic                     mdu_valid;
    logic                     mdu_ready;
    logic [REG_AW-1:0]        mdu_addr;
    logic [XLEN-1:0]          mdu_data;
    logic [REG_AW-1:0]        probe_addr;
    logic                     probe_hit;
    logic                     stall_req;
    logic                     rf_we;
    logic [REG_AW-1:0]        rf_addr;
    logic [XLEN-1:0]          rf_data;
    logic [$clog2(DEPTH):0]   buf_count;

    modport master (
        output wb_addr, wb_data, wb_write, mdu_valid, mdu_addr, mdu_data, probe_addr,
        input  mdu_ready, probe_hit, stall_req, rf_we, rf_addr, rf_data, buf_count
    );

    modport slave (
        input  wb_addr, wb_data, wb_write, mdu_valid, mdu_addr, mdu_data, probe_addr,
        output mdu_ready, probe_hit, stall_req, rf_we, rf_addr, rf_data, buf_count
    );
endinterface

// File: rtl/wb_req_fifo.sv
// Synchronous FIFO of write requests, exposing per-entry valid/addr for the hazard probe.
// Head is visible combinationally; caller must not push when full or pop when empty.
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  wb_req_t                       push_dat_i,
    input  logic                          pop_i,
    output logic [CW-1:0]                 count_o,
    output wb_req_t                       head_o,
    output logic [DEPTH-1:0]              ent_vld_o,
    output logic [DEPTH-1:0][REG_AW-1:0]  ent_addr_o
);
    wb_req_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow
    assign wr_ptr_d = wr_ptr_q + AW'(push_i);
    assign rd_ptr_d = rd_ptr_q + AW'(pop_i);
    assign count_d  = count_q + CW'(push_i) - CW'(pop_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Slot i is occupied when its distance from the read pointer is below the count
    always_comb begin
        ent_vld_o  = '0;
        ent_addr_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld_o[i]  = {1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q;
            ent_addr_o[i] = mem_q[i].addr;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline write-back first, then buffered MDU results, then MDU bypass.
// rf_* registered (1 cycle); mdu_ready is registered-state only; stall_req after STARVE_LIMIT blocked cycles.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                          pipe_act, mdu_acc, mdu_live;
    logic                          fifo_empty, pop, push, bypass;
    logic [CW-1:0]                 count;
    wb_req_t                       head, mdu_req;
    logic [DEPTH-1:0]              ent_vld;
    logic [DEPTH-1:0][REG_AW-1:0]  ent_addr;

    logic                          rf_we_q,  rf_we_d;
    wb_req_t                       rf_req_q, rf_req_d;
    logic [SW-1:0]                 cnt_q,    cnt_d;

    assign mdu_req  = '{addr: bus.mdu_addr, data: bus.mdu_data};
    assign pipe_act = bus.wb_write && addr_live(bus.wb_addr);

    // Gated by reset so the MDU sees no room while the block is held in reset
    assign bus.mdu_ready = reset && (count < CW'(DEPTH));
    assign mdu_acc       = bus.mdu_valid && bus.mdu_ready;
    assign mdu_live      = mdu_acc && addr_live(bus.mdu_addr);

    assign fifo_empty = (count == '0);
    assign pop        = !pipe_act && !fifo_empty;
    assign bypass     = !pipe_act && fifo_empty && mdu_live;
    assign push       = mdu_live && !bypass;

    wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (mdu_req),
        .pop_i      (pop),
        .count_o    (count),
        .head_o     (head),
        .ent_vld_o  (ent_vld),
        .ent_addr_o (ent_addr)
    );

    always_comb begin
        rf_we_d  = pipe_act || pop || bypass;
        rf_req_d = rf_req_q;
        if (pipe_act)    rf_req_d = '{addr: bus.wb_addr, data: bus.wb_data};
        else if (pop)    rf_req_d = head;
        else if (bypass) rf_req_d = mdu_req;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pop || fifo_empty)                cnt_d = '0;
        else if (cnt_q != SW'(STARVE_LIMIT)) cnt_d = cnt_q + SW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q  <= 1'b0;
            rf_req_q <= '0;
            cnt_q    <= '0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_req_q <= rf_req_d;
            cnt_q    <= cnt_d;
        end
    end

    // The rf_* register is deliberately not covered; its write lands next edge
    always_comb begin
        bus.probe_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_addr[i] == bus.probe_addr && addr_live(bus.probe_addr))
                bus.probe_hit = 1'b1;
        end
    end

    assign bus.stall_req = (cnt_q == SW'(STARVE_LIMIT));
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_req_q.addr;
    assign bus.rf_data   = rf_req_q.data;
    assign bus.buf_count = count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, bypass, priority/drain, full buffer, starvation, r0, mid-run reset.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIM   = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.wb_write  = wbw;
        bus.wb_addr   = wba;
        bus.wb_data   = wbd;
        bus.mdu_valid = mv;
        bus.mdu_addr  = ma;
        bus.mdu_data  = md;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(bus.rf_we), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(bus.rf_addr), 32'(a));
            chk({tag, ".data"}, bus.rf_data, d);
        end
    endtask

    task automatic chk_probe(input string tag, input logic [4:0] a, input logic exp);
        bus.probe_addr = a;
        #1;
        chk(tag, 32'(bus.probe_hit), 32'(exp));
    endtask

    initial begin
        // Reset held with random inputs
        bus.probe_addr = 5'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
            bus.probe_addr = 5'($urandom);
            tick();
        end
        chk("rst.rf_we",     32'(bus.rf_we),     32'd0);
        chk("rst.buf_count", 32'(bus.buf_count), 32'd0);
        chk("rst.mdu_ready", 32'(bus.mdu_ready), 32'd0);
        chk("rst.stall_req", 32'(bus.stall_req), 32'd0);
        chk("rst.probe_hit", 32'(bus.probe_hit), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.probe_addr = 5'd0;
        reset = 1'b1;
        #1;
        chk("rel.mdu_ready", 32'(bus.mdu_ready), 32'd1);
        chk("rel.stall_req", 32'(bus.stall_req), 32'd0);
        tick();
        chk_rf("rel", 1'b0, 5'd0, 32'd0);

        // Bypass into an idle port
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        tick();
        chk_rf("byp", 1'b1, 5'd5, 32'h1234);
        chk("byp.buf_count", 32'(bus.buf_count), 32'd0);

        // Pipeline wins, MDU result drains on the next idle cycle
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        tick();
        chk_rf("prio", 1'b1, 5'd3, 32'hA);
        chk("prio.buf_count", 32'(bus.buf_count), 32'd1);
        chk_probe("prio.probe7", 5'd7, 1'b1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk_rf("drain", 1'b1, 5'd7, 32'hB);
        chk("drain.buf_count", 32'(bus.buf_count), 32'd0);
        chk_probe("drain.probe7", 5'd7, 1'b0);
        tick();
        chk_rf("idle", 1'b0, 5'd0, 32'd0);

        // Fill the buffer behind a continuous pipeline write to r1
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h80);
        tick();
        chk("full.cnt1", 32'(bus.buf_count), 32'd1);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h90);
        #1;
        chk("full.rdy_before", 32'(bus.mdu_ready), 32'd1);
        tick();
        chk("full.cnt2", 32'(bus.buf_count), 32'd2);
        chk("full.rdy_after", 32'(bus.mdu_ready), 32'd0);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0);
        chk_probe("full.probe9",  5'd9,  1'b1);
        chk_probe("full.probe10", 5'd10, 1'b0);
        chk_probe("full.probe8",  5'd8,  1'b1);
        chk_probe("full.probe0",  5'd0,  1'b0);

        // Starvation: counter is 1 here, reaches LIM seven edges later
        repeat (6) tick();
        chk("starve.pre", 32'(bus.stall_req), 32'd0);
        tick();
        chk("starve.stall", 32'(bus.stall_req), 32'd1);
        chk("starve.cnt", 32'(bus.buf_count), 32'd2);
        chk_rf("starve", 1'b1, 5'd1, 32'h11);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0);
        tick();
        chk_rf("unstall", 1'b1, 5'd8, 32'h80);
        chk("unstall.stall", 32'(bus.stall_req), 32'd0);
        chk("unstall.cnt", 32'(bus.buf_count), 32'd1);
        chk("unstall.rdy", 32'(bus.mdu_ready), 32'd1);
        tick();
        chk_rf("pushpop", 1'b1, 5'd9, 32'h90);
        chk("pushpop.cnt", 32'(bus.buf_count), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_probe("pushpop.probe10", 5'd10, 1'b1);
        tick();
        chk_rf("last", 1'b1, 5'd10, 32'hA0);
        chk("last.cnt", 32'(bus.buf_count), 32'd0);

        // r0 handling
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
        tick();
        chk_rf("r0.setup", 1'b1, 5'd2, 32'h22);
        chk("r0.setup.cnt", 32'(bus.buf_count), 32'd1);
        drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
        tick();
        chk_rf("r0.wb", 1'b1, 5'd4, 32'h44);
        chk("r0.wb.cnt", 32'(bus.buf_count), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        #1;
        chk("r0.mdu.rdy", 32'(bus.mdu_ready), 32'd1);
        tick();
        chk_rf("r0.mdu", 1'b0, 5'd0, 32'd0);
        chk("r0.mdu.cnt", 32'(bus.buf_count), 32'd0);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'hBEEF);
        tick();
        chk_rf("r0.mdu_busy", 1'b1, 5'd6, 32'h66);
        chk("r0.mdu_busy.cnt", 32'(bus.buf_count), 32'd0);

        // Reset with a buffered result discards it
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC0);
        tick();
        chk("mrst.pre_cnt", 32'(bus.buf_count), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        reset = 1'b0;
        #1;
        chk("mrst.cnt", 32'(bus.buf_count), 32'd0);
        chk("mrst.rf_we", 32'(bus.rf_we), 32'd0);
        chk_probe("mrst.probe12", 5'd12, 1'b0);
        reset = 1'b1;
        tick();
        chk_rf("mrst.after", 1'b0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
